// File: rtl/window_stream_kxk.sv
`timescale 1ns/1ps
// KxK sliding-window generator: row-major pixels pass through K-1 line buffers and a
// KxK shift window; packed windows are emitted per layer over a multi-layer run.
module window_stream_kxk #(
    parameter int DATA_WIDTH  = 8,
    parameter int K           = 3,
    parameter int MAX_COLS    = 256,
    parameter int DIM_WIDTH   = 9,
    parameter int LAYER_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [DIM_WIDTH-1:0]          cfg_row_size,
    input  logic [DIM_WIDTH-1:0]          cfg_col_size,
    input  logic                          cfg_stride2_en,
    input  logic [LAYER_WIDTH-1:0]        cfg_no_of_layers,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_rdy,
    output logic [K*K*DATA_WIDTH-1:0]     out_data,
    output logic                          out_valid,
    input  logic                          out_rdy,
    output logic [LAYER_WIDTH-1:0]        out_layer_id,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err
);

    localparam int ADDR_WIDTH = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    localparam logic [DIM_WIDTH-1:0] K_DIM      = DIM_WIDTH'(K);
    localparam logic [DIM_WIDTH-1:0] K_M1       = DIM_WIDTH'(K - 1);
    localparam logic [DIM_WIDTH-1:0] ONE        = DIM_WIDTH'(1);
    localparam logic [DIM_WIDTH-1:0] TWO        = DIM_WIDTH'(2);
    localparam logic [DIM_WIDTH:0]   MAX_C_DIM  = (DIM_WIDTH + 1)'(MAX_COLS);
    localparam logic                 K_M1_ODD   = (((K - 1) % 2) == 1);
    localparam logic [LAYER_WIDTH-1:0] LAYER_ONE = LAYER_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state;
    logic [DIM_WIDTH-1:0]    row_size;
    logic [DIM_WIDTH-1:0]    col_size;
    logic                    stride2;
    logic [LAYER_WIDTH-1:0]  num_layers;
    logic [DIM_WIDTH-1:0]    row;
    logic [DIM_WIDTH-1:0]    col;
    logic [LAYER_WIDTH-1:0]  layer_id;

    logic [DATA_WIDTH-1:0]   line_buf [K-1][MAX_COLS];
    logic [DATA_WIDTH-1:0]   win      [K][K];
    logic [DATA_WIDTH-1:0]   win_next [K][K];
    logic [DATA_WIDTH-1:0]   col_new  [K];
    logic [K*K*DATA_WIDTH-1:0] win_flat;
    logic [ADDR_WIDTH-1:0]   col_addr;

    logic accept;
    logic emit;
    logic win_last;
    logic last_col;
    logic last_row;
    logic last_layer;
    logic bad_cfg;

    assign in_rdy     = (state == RUN) && (!out_valid || out_rdy);
    assign accept     = in_valid && in_rdy;
    assign col_addr   = col[ADDR_WIDTH-1:0];
    assign last_col   = (col == col_size - ONE);
    assign last_row   = (row == row_size - ONE);
    assign last_layer = (layer_id == num_layers - LAYER_ONE);

    // With stride 2 the window anchor (row-K+1, col-K+1) must be even in both axes.
    assign emit = (row >= K_M1) && (col >= K_M1) &&
                  (!stride2 || ((row[0] == K_M1_ODD) && (col[0] == K_M1_ODD)));

    assign win_last = stride2 ? ((row >= row_size - TWO) && (col >= col_size - TWO))
                              : (last_row && last_col);

    assign bad_cfg = (cfg_row_size < K_DIM) || (cfg_col_size < K_DIM) ||
                     ({1'b0, cfg_col_size} > MAX_C_DIM) || (cfg_no_of_layers == '0);

    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            col_new[r] = line_buf[r][col_addr];
        end
        col_new[K-1] = in_data;
    end

    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_next[r][c] = win[r][c+1];
            end
            win_next[r][K-1] = col_new[r];
        end
    end

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_flat[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = win_next[r][c];
            end
        end
    end

    // Line buffers shift one row older per column visit; contents need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < K - 2; r++) begin
                line_buf[r][col_addr] <= line_buf[r+1][col_addr];
            end
            line_buf[K-2][col_addr] <= in_data;
            win <= win_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            row_size     <= '0;
            col_size     <= '0;
            stride2      <= 1'b0;
            num_layers   <= '0;
            row          <= '0;
            col          <= '0;
            layer_id     <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_layer_id <= '0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (out_valid && out_rdy) begin
                out_valid <= 1'b0;
            end
            if (accept && emit) begin
                out_valid    <= 1'b1;
                out_data     <= win_flat;
                out_layer_id <= layer_id;
                out_last     <= win_last;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (bad_cfg) begin
                            cfg_err <= 1'b1;
                            done    <= 1'b1;
                        end else begin
                            row_size   <= cfg_row_size;
                            col_size   <= cfg_col_size;
                            stride2    <= cfg_stride2_en;
                            num_layers <= cfg_no_of_layers;
                            row        <= '0;
                            col        <= '0;
                            layer_id   <= '0;
                            cfg_err    <= 1'b0;
                            busy       <= 1'b1;
                            state      <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last_col) begin
                            col <= '0;
                            if (last_row) begin
                                row      <= '0;
                                layer_id <= layer_id + LAYER_ONE;
                                if (last_layer) begin
                                    state <= DRAIN;
                                end
                            end else begin
                                row <= row + ONE;
                            end
                        end else begin
                            col <= col + ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (!out_valid || out_rdy) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_window_stream_kxk.sv
`timescale 1ns/1ps
// Self-checking bench for window_stream_kxk: directed runs driven from a pixel-function
// golden model that fills a window scoreboard, popped on every output handshake.
module tb_window_stream_kxk;

    localparam int DW   = 8;
    localparam int K    = 3;
    localparam int MAXC = 256;
    localparam int DIMW = 9;
    localparam int LW   = 16;
    localparam int WW   = K * K * DW;
    localparam int TMO  = 5000;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [DIMW-1:0] cfg_row_size = '0;
    logic [DIMW-1:0] cfg_col_size = '0;
    logic            cfg_stride2_en = 1'b0;
    logic [LW-1:0]   cfg_no_of_layers = '0;
    logic [DW-1:0]   in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_rdy;
    logic [WW-1:0]   out_data;
    logic            out_valid;
    logic            out_rdy = 1'b0;
    logic [LW-1:0]   out_layer_id;
    logic            out_last;
    logic            busy;
    logic            done;
    logic            cfg_err;

    typedef struct {
        logic [WW-1:0] data;
        logic [LW-1:0] layer;
        logic          last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int checks    = 0;
    int errors    = 0;
    int win_count = 0;
    int accepted  = 0;
    int rdy_mode  = 1;
    int base      = 0;
    bit abort     = 1'b0;

    int bad_r [4] = '{4, 4, 4, 2};
    int bad_c [4] = '{2, 257, 4, 4};
    int bad_l [4] = '{1, 1, 0, 1};

    window_stream_kxk #(
        .DATA_WIDTH(DW), .K(K), .MAX_COLS(MAXC), .DIM_WIDTH(DIMW), .LAYER_WIDTH(LW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .cfg_row_size(cfg_row_size),
        .cfg_col_size(cfg_col_size),
        .cfg_stride2_en(cfg_stride2_en),
        .cfg_no_of_layers(cfg_no_of_layers),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_rdy(in_rdy),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_rdy(out_rdy),
        .out_layer_id(out_layer_id),
        .out_last(out_last),
        .busy(busy),
        .done(done),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       out_rdy = 1'b0;
            2:       out_rdy = ($urandom_range(0, 7) == 0);
            default: out_rdy = 1'b1;
        endcase
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: observed no end of test, required finish before 90000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DW-1:0] pix(input int l, input int r, input int c, input int ncols);
        int v;
        v = l * 37 + r * ncols + c;
        return DW'(v);
    endfunction

    function automatic logic [WW-1:0] win_exp(input int l, input int wr, input int wc, input int ncols);
        logic [WW-1:0] w;
        w = '0;
        for (int rr = 0; rr < K; rr++) begin
            for (int cc = 0; cc < K; cc++) begin
                w[(rr*K+cc)*DW +: DW] = pix(l, wr + rr, wc + cc, ncols);
            end
        end
        return w;
    endfunction

    task automatic check_val(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, required %0h", tag, obs, req);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b, required %b", tag, obs, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int nr, input int nc, input bit s2, input int nl);
        cfg_row_size     = DIMW'(nr);
        cfg_col_size     = DIMW'(nc);
        cfg_stride2_en   = s2;
        cfg_no_of_layers = LW'(nl);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_bit({tag, "_out_valid"}, out_valid, 1'b0);
        check_val({tag, "_out_data"}, out_data, '0);
        check_val({tag, "_layer_id"}, WW'(out_layer_id), '0);
        check_bit({tag, "_out_last"}, out_last, 1'b0);
        check_bit({tag, "_busy"}, busy, 1'b0);
        check_bit({tag, "_done"}, done, 1'b0);
        check_bit({tag, "_cfg_err"}, cfg_err, 1'b0);
        check_bit({tag, "_in_rdy"}, in_rdy, 1'b0);
    endtask

    // Drives nl layers of nr x nc pixels and pushes the model's windows as pixels are accepted.
    task automatic drive_run(input int nr, input int nc, input int nl, input bit s2);
        int   step;
        int   lr;
        int   lc;
        int   n;
        exp_t e;
        step = s2 ? 2 : 1;
        lr = (K - 1) + step * ((nr - K) / step);
        lc = (K - 1) + step * ((nc - K) / step);
        for (int l = 0; l < nl; l++) begin
            for (int r = 0; r < nr; r++) begin
                for (int c = 0; c < nc; c++) begin
                    if (abort) begin
                        in_valid = 1'b0;
                        return;
                    end
                    in_valid = 1'b1;
                    in_data  = pix(l, r, c, nc);
                    n = 0;
                    @(negedge clk);
                    while (!in_rdy && !abort && n < TMO) begin
                        @(negedge clk);
                        n++;
                    end
                    if (abort) begin
                        in_valid = 1'b0;
                        return;
                    end
                    checks++;
                    assert (in_rdy === 1'b1) else begin
                        errors++;
                        $error("[TB] FAIL in_rdy_timeout: observed in_rdy=%b after %0d cycles, required 1", in_rdy, n);
                    end
                    if (in_rdy !== 1'b1) begin
                        in_valid = 1'b0;
                        return;
                    end
                    if (r >= K - 1 && c >= K - 1 &&
                        ((r - (K - 1)) % step == 0) && ((c - (K - 1)) % step == 0)) begin
                        e.data  = win_exp(l, r - (K - 1), c - (K - 1), nc);
                        e.layer = LW'(l);
                        e.last  = (r == lr) && (c == lc);
                        sb.push_back(e);
                    end
                    accepted++;
                    tick();
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < TMO) begin
            @(negedge clk);
            n++;
        end
        check_bit({tag, "_done_seen"}, done, 1'b1);
        @(negedge clk);
        check_bit({tag, "_done_width"}, done, 1'b0);
        check_bit({tag, "_busy_after"}, busy, 1'b0);
        tick();
    endtask

    // Scoreboard consumer: a window is taken whenever out_valid and out_rdy meet at the next edge.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_rdy) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("[TB] FAIL sb_unexpected: observed window %0h, required none", out_data);
            end
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check_val("win_data", out_data, mon_e.data);
                check_val("win_layer", WW'(out_layer_id), WW'(mon_e.layer));
                check_bit("win_last", out_last, mon_e.last);
                win_count++;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        tick();
        reset_n = 1'b1;
        tick();

        $display("[TB] T1: 4x4 ramp, stride 1, with an ignored start while busy");
        base = win_count;
        do_start(4, 4, 1'b0, 1);
        @(negedge clk);
        check_bit("t1_busy", busy, 1'b1);
        check_bit("t1_cfg_err", cfg_err, 1'b0);
        tick();
        do_start(13, 13, 1'b1, 3);
        drive_run(4, 4, 1, 1'b0);
        wait_done("t1");
        check_val("t1_windows", WW'(win_count - base), WW'(4));
        check_val("t1_sb_empty", WW'(sb.size()), '0);

        $display("[TB] T3: 5x5 ramp, stride 2");
        base = win_count;
        do_start(5, 5, 1'b1, 1);
        drive_run(5, 5, 1, 1'b1);
        wait_done("t3");
        check_val("t3_windows", WW'(win_count - base), WW'(4));

        $display("[TB] T4: rejected configurations");
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_start(bad_r[i], bad_c[i], 1'b0, bad_l[i]);
            @(negedge clk);
            check_bit("t4_done", done, 1'b1);
            check_bit("t4_cfg_err", cfg_err, 1'b1);
            check_bit("t4_busy", busy, 1'b0);
            check_bit("t4_in_rdy", in_rdy, 1'b0);
            @(negedge clk);
            check_bit("t4_done_width", done, 1'b0);
            check_bit("t4_cfg_err_sticky", cfg_err, 1'b1);
            tick();
        end
        in_valid = 1'b0;

        $display("[TB] T5: output stall of 20 cycles");
        rdy_mode = 0;
        tick();
        base = win_count;
        accepted = 0;
        do_start(4, 4, 1'b0, 1);
        @(negedge clk);
        check_bit("t5_cfg_err_cleared", cfg_err, 1'b0);
        tick();
        fork
            drive_run(4, 4, 1, 1'b0);
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!out_valid && n < TMO) begin
                    @(negedge clk);
                    n++;
                end
                check_bit("t5_valid", out_valid, 1'b1);
                repeat (20) begin
                    check_val("t5_hold_data", out_data, win_exp(0, 0, 0, 4));
                    check_bit("t5_in_rdy", in_rdy, 1'b0);
                    @(negedge clk);
                end
                check_val("t5_accepted", WW'(accepted), WW'(11));
                rdy_mode = 1;
            end
        join
        wait_done("t5");
        check_val("t5_windows", WW'(win_count - base), WW'(4));

        $display("[TB] T2: 13x13 x 16 layers, sparse out_rdy");
        rdy_mode = 2;
        base = win_count;
        do_start(13, 13, 1'b0, 16);
        drive_run(13, 13, 16, 1'b0);
        wait_done("t2");
        check_val("t2_windows", WW'(win_count - base), WW'(1936));
        rdy_mode = 1;

        $display("[TB] T6: reset mid-run, then 2 layers of 4x4");
        accepted = 0;
        abort = 1'b0;
        do_start(4, 4, 1'b0, 5);
        fork
            drive_run(4, 4, 5, 1'b0);
            begin
                int n;
                n = 0;
                while (accepted < 53 && n < TMO) begin
                    @(negedge clk);
                    n++;
                end
                tick();
                reset_n = 1'b0;
                abort = 1'b1;
            end
        join
        sb.delete();
        @(negedge clk);
        check_idle_outputs("t6_reset");
        repeat (2) @(negedge clk);
        tick();
        reset_n = 1'b1;
        abort = 1'b0;
        tick();
        base = win_count;
        do_start(4, 4, 1'b0, 2);
        drive_run(4, 4, 2, 1'b0);
        wait_done("t6");
        check_val("t6_windows", WW'(win_count - base), WW'(8));
        check_val("t6_sb_empty", WW'(sb.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
